// File: rtl/rv_alu_arb_pkg.sv
// rv_defs: ALU opcode map, arbiter FSM encoding and request bundle
// shared by rv_alu, rv_alu_arb and the interface users.
package rv_defs;

    localparam int XLEN_C = 32;

    // Codes 4'd8 and 4'd11..4'd15 are deliberately left unencoded.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd9,
        OP_AND  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [3:0]        op;
        logic [XLEN_C-1:0] a;
        logic [XLEN_C-1:0] b;
        logic              id;
    } arb_req_t;

endpackage

// File: rtl/rv_alu_arb_if.sv
// Two-requester ALU request/response bundle; master drives requests,
// slave (the arbiter) answers on a shared result bus.
interface rv_alu_arb_if #(
    parameter int XLEN = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [7:0]        req_op;
    logic [2*XLEN-1:0] req_a;
    logic [2*XLEN-1:0] req_b;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_cmp;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_cmp, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_cmp, rsp_err
    );
endinterface

// File: rtl/rv_alu_arb_alu.sv
// rv_alu: purely combinational RV32 integer ALU; shifts use b[4:0],
// unencoded opcodes yield zero.
module rv_alu
    import rv_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y
);
    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_SLL:  o_y = i_a << w_shamt;
            OP_SLT:  o_y = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            OP_SLTU: o_y = {{(XLEN-1){1'b0}}, i_a < i_b};
            OP_XOR:  o_y = i_a ^ i_b;
            OP_SRL:  o_y = i_a >> w_shamt;
            OP_SRA:  o_y = $unsigned($signed(i_a) >>> w_shamt);
            OP_OR:   o_y = i_a | i_b;
            OP_AND:  o_y = i_a & i_b;
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/rv_alu_arb.sv
// rv_alu_arb: two requesters share one rv_alu via IDLE/EXEC/RESP FSM.
// RV_ALU_ARB_RR_EN selects round-robin; otherwise requester 0 has priority.
module rv_alu_arb
    import rv_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    rv_alu_arb_if.slave  bus
);
    arb_state_e      r_state;
    arb_state_e      w_next;
    arb_req_t        r_req;
    logic [XLEN-1:0] r_res;
    logic            r_err;
    logic [XLEN-1:0] w_alu_y;
    logic            w_gnt;
    logic            w_hs;
    logic            w_legal;
    logic            w_resp;
    logic [1:0]      w_ready;

`ifdef RV_ALU_ARB_RR_EN
    logic            r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_hs) begin
            r_last <= w_gnt;
        end
    end
`endif

    // w_gnt is the granted requester id; meaningless when nobody is valid
    always_comb begin
        w_gnt = ~bus.req_valid[0];
        if (&bus.req_valid) begin
`ifdef RV_ALU_ARB_RR_EN
            w_gnt = ~r_last;
`else
            w_gnt = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 2'b00;
        w_hs    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!rst && bus.req_valid[w_gnt]) begin
                    w_ready[w_gnt] = 1'b1;
                    w_hs           = 1'b1;
                    w_next         = ST_EXEC;
                end
            end
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready[r_req.id]) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        case (r_req.op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    rv_alu #(.XLEN(XLEN)) u_alu (
        .i_op (r_req.op),
        .i_a  (r_req.a),
        .i_b  (r_req.b),
        .o_y  (w_alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_req.op <= w_gnt ? bus.req_op[7:4] : bus.req_op[3:0];
                r_req.a  <= w_gnt ? bus.req_a[2*XLEN-1:XLEN]
                                  : bus.req_a[XLEN-1:0];
                r_req.b  <= w_gnt ? bus.req_b[2*XLEN-1:XLEN]
                                  : bus.req_b[XLEN-1:0];
                r_req.id <= w_gnt;
            end
            // illegal ops must not leak a stale or partial result
            if (r_state == ST_EXEC) begin
                r_res <= w_legal ? w_alu_y : '0;
                r_err <= ~w_legal;
            end
        end
    end

    assign w_resp        = (r_state == ST_RESP) && !rst;
    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = w_resp ? (r_req.id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data  = w_resp ? r_res : '0;
    assign bus.rsp_cmp   = w_resp & r_res[0];
    assign bus.rsp_err   = w_resp & r_err;
endmodule

// File: tb/tb_rv_alu_arb.sv
// Self-checking bench for rv_alu_arb: directed scenarios plus a random
// run against a latency/arbitration reference model.
module tb_rv_alu_arb;
    import rv_defs::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef RV_ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    rv_alu_arb_if #(.XLEN(32)) bus();

    rv_alu_arb #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic ref_err(input logic [3:0] op);
        return (op == 4'd8) || (op >= 4'd11);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint ua, ub, sa, d, q;
        int     sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'(int'(a));
        sh = int'(b % 32);
        d  = longint'(1) << sh;
        case (op)
            OP_ADD:  return 32'(ua + ub);
            OP_SUB:  return 32'(ua - ub);
            OP_SLL:  return 32'(ua * d);
            OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_SRL:  return 32'(ua / d);
            OP_SRA: begin
                q = sa / d;
                if ((sa % d) != 0 && sa < 0) q = q - 1;
                return 32'(q);
            end
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input logic [1:0] v, input logic [3:0] o0,
                         input logic [3:0] o1, input logic [31:0] a0,
                         input logic [31:0] b0, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [1:0] rr);
        bus.req_valid = v;
        bus.req_op    = {o1, o0};
        bus.req_a     = {a1, a0};
        bus.req_b     = {b1, b0};
        bus.rsp_ready = rr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 4'd0, 4'd0, 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(2'b11, OP_ADD, OP_ADD, 1, 2, 3, 4, 2'b11);
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 00", bus.req_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_cmp, bus.rsp_err} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_rsp: got v=%b d=%h c=%b e=%b want all 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_cmp, bus.rsp_err);
        end
        rst = 1'b0;
        drive(2'b00, 4'd0, 4'd0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic test_single();
        do_reset();
        drive(2'b01, OP_ADD, OP_ADD, 5, 7, 0, 0, 2'b11);
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 01", bus.req_ready);
        end
        @(negedge clk);
        drive(2'b00, OP_ADD, OP_ADD, 5, 7, 0, 0, 2'b11);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL single_exec_valid: got %b want 00", bus.rsp_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'd12 ||
            bus.rsp_cmp !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_rsp: got v=%b d=%h c=%b e=%b want v=01 d=0000000c c=0 e=0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_cmp, bus.rsp_err);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL single_done: got %b want 00", bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  er[6];
        logic [1:0]  ev[6];
        logic [31:0] ed[6];
        logic [31:0] r0, r1;
        r0 = ref_alu(OP_SUB, 32'd3, 32'd5);
        r1 = ref_alu(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        er = '{2'b01, 2'b00, 2'b00, RR ? 2'b10 : 2'b01, 2'b00, 2'b00};
        ev = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, RR ? 2'b10 : 2'b01};
        ed = '{32'd0, 32'd0, r0, 32'd0, 32'd0, RR ? r1 : r0};
        do_reset();
        drive(2'b11, OP_SUB, OP_SLT, 3, 5, 32'hFFFF_FFFF, 1, 2'b11);
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== er[k] || bus.rsp_valid !== ev[k] ||
                bus.rsp_data !== ed[k] || bus.rsp_cmp !== ed[k][0]) begin
                n_bad++;
                $display("FAIL contention[%0d]: got r=%b v=%b d=%h c=%b want r=%b v=%b d=%h c=%b",
                         k, bus.req_ready, bus.rsp_valid, bus.rsp_data,
                         bus.rsp_cmp, er[k], ev[k], ed[k], ed[k][0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(2'b10, OP_ADD, OP_SRA, 0, 0, 32'h8000_0000, 32'h24, 2'b00);
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_ready: got %b want 10", bus.req_ready);
        end
        @(negedge clk);
        drive(2'b11, OP_ADD, OP_SRA, 0, 0, 32'h8000_0000, 32'h24, 2'b01);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'hF800_0000 ||
                bus.rsp_cmp !== 1'b0 || bus.rsp_err !== 1'b0 ||
                bus.req_ready !== 2'b00) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%b e=%b r=%b want v=10 d=f8000000 c=0 e=0 r=00",
                         k, bus.rsp_valid, bus.rsp_data, bus.rsp_cmp,
                         bus.rsp_err, bus.req_ready);
            end
            if (k == 4) drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b10);
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_release: got v=%b r=%b want v=00 r=00",
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  ops[5];
        logic [31:0] a, b, ed;
        logic        ee;
        ops = '{OP_XOR, 4'b1100, 4'b1000, 4'b1011, 4'b1111};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            a  = (k == 0) ? 32'hFFFF_FFFF : $urandom();
            b  = (k == 0) ? 32'd0 : $urandom();
            ee = ref_err(ops[k]);
            ed = ee ? 32'd0 : ref_alu(ops[k], a, b);
            drive(2'b01, ops[k], 4'd0, a, b, 0, 0, 2'b01);
            @(negedge clk);
            drive(2'b00, ops[k], 4'd0, a, b, 0, 0, 2'b01);
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== ed ||
                bus.rsp_cmp !== ed[0] || bus.rsp_err !== ee) begin
                n_bad++;
                $display("FAIL illegal[op=%h]: got v=%b d=%h c=%b e=%b want v=01 d=%h c=%b e=%b",
                         ops[k], bus.rsp_valid, bus.rsp_data, bus.rsp_cmp,
                         bus.rsp_err, ed, ed[0], ee);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(2'b01, OP_SLL, 4'd0, 32'h1, 32'h3, 0, 0, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b01, OP_SLL, 4'd0, 32'h1, 32'h3, 0, 0, 2'b11);
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL rstmid_ready: got %b want 00", bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== 2'b00) begin
                n_bad++;
                $display("FAIL rstmid_pulse[%0d]: got %b want 00", k, bus.rsp_valid);
            end
            @(negedge clk);
        end
        drive(2'b01, OP_XOR, 4'd0, 32'hF0, 32'hFF, 0, 0, 2'b11);
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'h0F) begin
            n_bad++;
            $display("FAIL rstmid_fresh: got v=%b d=%h want v=01 d=0000000f",
                     bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_random(input int ncyc);
        int          phase;
        int          nrsp;
        logic        mid, merr, last, g;
        logic [31:0] mdata;
        logic [1:0]  v, rr, eready, evalid;
        logic [3:0]  o0, o1;
        logic [31:0] a0, b0, a1, b1;
        do_reset();
        phase = 0;
        nrsp  = 0;
        mid   = 1'b0;
        merr  = 1'b0;
        mdata = 32'd0;
        last  = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            v  = 2'($urandom_range(0, 3));
            rr = 2'($urandom_range(0, 3));
            o0 = 4'($urandom_range(0, 15));
            o1 = 4'($urandom_range(0, 15));
            a0 = pick();
            b0 = pick();
            a1 = pick();
            b1 = pick();
            drive(v, o0, o1, a0, b0, a1, b1, rr);
            #1;
            g      = (v == 2'b11) ? (RR ? ~last : 1'b0) : ~v[0];
            eready = (phase == 0 && v[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
            evalid = (phase == 2) ? (mid ? 2'b10 : 2'b01) : 2'b00;
            n_cmp++;
            if (bus.req_ready !== eready) begin
                n_bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.req_ready, eready);
            end
            n_cmp++;
            if (bus.rsp_valid !== evalid ||
                bus.rsp_data !== ((phase == 2) ? mdata : 32'd0) ||
                bus.rsp_cmp !== ((phase == 2) & mdata[0]) ||
                bus.rsp_err !== ((phase == 2) & merr)) begin
                n_bad++;
                $display("FAIL rand_rsp[%0d]: got v=%b d=%h c=%b e=%b want v=%b d=%h e=%b",
                         c, bus.rsp_valid, bus.rsp_data, bus.rsp_cmp,
                         bus.rsp_err, evalid, (phase == 2) ? mdata : 32'd0,
                         (phase == 2) & merr);
            end
            @(posedge clk);
            if (phase == 0 && eready != 2'b00) begin
                phase = 1;
                mid   = g;
                last  = g;
                merr  = ref_err(g ? o1 : o0);
                mdata = merr ? 32'd0 : ref_alu(g ? o1 : o0, g ? a1 : a0, g ? b1 : b0);
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2 && rr[mid]) begin
                phase = 0;
                nrsp++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (nrsp < 10) begin
            n_bad++;
            $display("FAIL rand_progress: got %0d responses want >= 10", nrsp);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 4'd0, 4'd0, 0, 0, 0, 0, 2'b00);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
